// File: rtl/pc_pilha.sv
// Program counter with a hardware return-address stack for call/ret.
// Latency 1: every control effect shows on saida one edge later; stall freezes all state.
module pc_pilha #(
    parameter int                   LARGURA      = 32,
    parameter int                   PROFUNDIDADE = 8,
    parameter logic [LARGURA-1:0]   VETOR_RESET  = '0,
    parameter logic [LARGURA-1:0]   INCREMENTO   = 1,
    parameter int                   LARG_DESL    = 16
) (
    input  logic                          clock,
    input  logic                          reseta,
    input  logic                          stall,
    input  logic                          halt,
    input  logic                          jump,
    input  logic                          branch,
    input  logic                          call,
    input  logic                          ret,
    input  logic [LARGURA-1:0]            endereco,
    input  logic [LARG_DESL-1:0]          deslocamento,
    output logic [LARGURA-1:0]            saida,
    output logic [$clog2(PROFUNDIDADE):0] nivel,
    output logic                          pilha_cheia,
    output logic                          pilha_vazia,
    output logic [1:0]                    erro_pilha
);

    localparam int PW = $clog2(PROFUNDIDADE);
    localparam int NW = PW + 1;

    logic [LARGURA-1:0] pilha [PROFUNDIDADE];
    logic [LARGURA-1:0] desl_ext;
    logic [LARGURA-1:0] proximo_seq;
    logic [NW-1:0]      nivel_m1;
    logic [PW-1:0]      idx_topo;
    logic [PW-1:0]      idx_push;

    assign desl_ext    = LARGURA'($signed(deslocamento));
    assign proximo_seq = saida + INCREMENTO;
    assign nivel_m1    = nivel - NW'(1);
    assign idx_topo    = nivel_m1[PW-1:0];
    assign idx_push    = nivel[PW-1:0];

    assign pilha_cheia = (nivel == NW'(PROFUNDIDADE));
    assign pilha_vazia = (nivel == '0);

    // The stack array is deliberately left out of the reset branch: only
    // nivel defines which entries are live, so stale contents are harmless.
    always_ff @(posedge clock or negedge reseta) begin
        if (!reseta) begin
            saida      <= VETOR_RESET;
            nivel      <= '0;
            erro_pilha <= '0;
        end else if (!stall) begin
            if (ret) begin
                if (pilha_vazia) begin
                    erro_pilha[1] <= 1'b1;
                end else begin
                    saida <= pilha[idx_topo];
                    nivel <= nivel_m1;
                end
            end else if (call) begin
                saida <= endereco;
                if (pilha_cheia) begin
                    erro_pilha[0] <= 1'b1;
                end else begin
                    pilha[idx_push] <= proximo_seq;
                    nivel           <= nivel + NW'(1);
                end
            end else if (jump) begin
                saida <= endereco;
            end else if (branch) begin
                saida <= saida + desl_ext;
            end else if (!halt) begin
                saida <= proximo_seq;
            end
        end
    end

endmodule

// File: tb/tb_pc_pilha.sv
// Randomized and directed bench for pc_pilha: a 32-bit/depth-8 instance and an
// 8-bit/depth-2 instance share stimulus and are compared against an array model.
module tb_pc_pilha;

    logic        clock = 1'b0;
    logic        reseta;
    logic        stall, halt, jump, branch, call, ret;
    logic [31:0] endereco;
    logic [15:0] deslocamento;
    logic [7:0]  endereco_b;

    logic [31:0] saida_a;
    logic [3:0]  nivel_a;
    logic        cheia_a, vazia_a;
    logic [1:0]  erro_a;

    logic [7:0]  saida_b;
    logic [1:0]  nivel_b;
    logic        cheia_b, vazia_b;
    logic [1:0]  erro_b;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: index 0 = instance a, index 1 = instance b.
    logic [31:0] m_pc   [2];
    logic [31:0] m_stk  [2][64];
    int          m_lvl  [2];
    logic [1:0]  m_err  [2];
    int          m_prof [2] = '{8, 2};
    logic [31:0] m_mask [2] = '{32'hFFFF_FFFF, 32'h0000_00FF};

    assign endereco_b = endereco[7:0];

    always #5 clock = ~clock;

    pc_pilha dut_a (
        .clock(clock), .reseta(reseta), .stall(stall), .halt(halt), .jump(jump),
        .branch(branch), .call(call), .ret(ret), .endereco(endereco),
        .deslocamento(deslocamento), .saida(saida_a), .nivel(nivel_a),
        .pilha_cheia(cheia_a), .pilha_vazia(vazia_a), .erro_pilha(erro_a)
    );

    pc_pilha #(.LARGURA(8), .PROFUNDIDADE(2)) dut_b (
        .clock(clock), .reseta(reseta), .stall(stall), .halt(halt), .jump(jump),
        .branch(branch), .call(call), .ret(ret), .endereco(endereco_b),
        .deslocamento(deslocamento), .saida(saida_b), .nivel(nivel_b),
        .pilha_cheia(cheia_b), .pilha_vazia(vazia_b), .erro_pilha(erro_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pc[k]  = 32'd0;
            m_lvl[k] = 0;
            m_err[k] = 2'b00;
        end
    endtask

    task automatic model_step(input int k);
        logic [31:0] sx;
        sx = {{16{deslocamento[15]}}, deslocamento};
        if (stall) begin
            // frozen
        end else if (ret) begin
            if (m_lvl[k] == 0) m_err[k][1] = 1'b1;
            else begin
                m_lvl[k] = m_lvl[k] - 1;
                m_pc[k]  = m_stk[k][m_lvl[k]];
            end
        end else if (call) begin
            if (m_lvl[k] == m_prof[k]) m_err[k][0] = 1'b1;
            else begin
                m_stk[k][m_lvl[k]] = (m_pc[k] + 32'd1) & m_mask[k];
                m_lvl[k] = m_lvl[k] + 1;
            end
            m_pc[k] = endereco & m_mask[k];
        end else if (jump) begin
            m_pc[k] = endereco & m_mask[k];
        end else if (branch) begin
            m_pc[k] = (m_pc[k] + sx) & m_mask[k];
        end else if (!halt) begin
            m_pc[k] = (m_pc[k] + 32'd1) & m_mask[k];
        end
    endtask

    task automatic check_all();
        chk("a_saida", saida_a, m_pc[0]);
        chk("a_nivel", {28'd0, nivel_a}, m_lvl[0]);
        chk("a_erro",  {30'd0, erro_a}, {30'd0, m_err[0]});
        chk("a_cheia", {31'd0, cheia_a}, {31'd0, (m_lvl[0] == m_prof[0])});
        chk("a_vazia", {31'd0, vazia_a}, {31'd0, (m_lvl[0] == 0)});
        chk("b_saida", {24'd0, saida_b}, m_pc[1]);
        chk("b_nivel", {30'd0, nivel_b}, m_lvl[1]);
        chk("b_erro",  {30'd0, erro_b}, {30'd0, m_err[1]});
        chk("b_cheia", {31'd0, cheia_b}, {31'd0, (m_lvl[1] == m_prof[1])});
        chk("b_vazia", {31'd0, vazia_b}, {31'd0, (m_lvl[1] == 0)});
    endtask

    // Called at a falling edge: drive, let one rising edge act, check at the next falling edge.
    task automatic step(input logic st, input logic hl, input logic jp, input logic br,
                        input logic cl, input logic rt, input logic [31:0] en,
                        input logic [15:0] ds);
        stall = st; halt = hl; jump = jp; branch = br; call = cl; ret = rt;
        endereco = en; deslocamento = ds;
        @(posedge clock);
        model_step(0);
        model_step(1);
        @(negedge clock);
        check_all();
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 32'd0, 16'd0);
    endtask

    task automatic do_reset();
        stall = 0; halt = 0; jump = 0; branch = 0; call = 0; ret = 0;
        reseta = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clock);
        reseta = 1'b1;
    endtask

    initial begin
        reseta = 1'b0;
        stall = 0; halt = 0; jump = 0; branch = 0; call = 0; ret = 0;
        endereco = '0; deslocamento = '0;
        #1;
        model_reset();
        check_all();
        chk("rst_saida", saida_a, 32'd0);
        @(negedge clock);
        reseta = 1'b1;

        // Sequential increment and 8-bit wrap
        for (int i = 0; i < 4; i++) begin
            idle();
            chk("inc_seq", saida_a, i + 1);
        end
        step(0, 0, 1, 0, 0, 0, 32'd255, 16'd0);
        idle();
        chk("wrap_b", {24'd0, saida_b}, 32'd0);
        chk("nowrap_a", saida_a, 32'd256);

        // Nested call/ret
        do_reset();
        step(0, 0, 1, 0, 0, 0, 32'd10, 16'd0);
        step(0, 0, 0, 0, 1, 0, 32'd100, 16'd0);
        chk("nest_pc1", saida_a, 32'd100); chk("nest_lv1", {28'd0, nivel_a}, 32'd1);
        step(0, 0, 0, 0, 1, 0, 32'd200, 16'd0);
        chk("nest_pc2", saida_a, 32'd200); chk("nest_lv2", {28'd0, nivel_a}, 32'd2);
        step(0, 0, 0, 0, 0, 1, 32'd0, 16'd0);
        chk("nest_pc3", saida_a, 32'd101); chk("nest_lv3", {28'd0, nivel_a}, 32'd1);
        step(0, 0, 0, 0, 0, 1, 32'd0, 16'd0);
        chk("nest_pc4", saida_a, 32'd11); chk("nest_lv4", {28'd0, nivel_a}, 32'd0);

        // Overflow then underflow on the depth-2 instance
        do_reset();
        step(0, 0, 0, 0, 1, 0, 32'd30, 16'd0);
        step(0, 0, 0, 0, 1, 0, 32'd40, 16'd0);
        step(0, 0, 0, 0, 1, 0, 32'd50, 16'd0);
        chk("ovf_nivel", {30'd0, nivel_b}, 32'd2);
        chk("ovf_erro", {30'd0, erro_b}, 32'd1);
        chk("ovf_saida", {24'd0, saida_b}, 32'd50);
        step(0, 0, 0, 0, 0, 1, 32'd0, 16'd0);
        chk("pop1", {24'd0, saida_b}, 32'd31);
        step(0, 0, 0, 0, 0, 1, 32'd0, 16'd0);
        chk("pop2", {24'd0, saida_b}, 32'd1);
        step(0, 0, 0, 0, 0, 1, 32'd0, 16'd0);
        chk("unf_saida", {24'd0, saida_b}, 32'd1);
        chk("unf_erro", {30'd0, erro_b}, 32'd3);

        // Priority: ret beats call and jump; stall beats everything
        do_reset();
        step(0, 0, 1, 0, 0, 0, 32'd6, 16'd0);
        step(0, 0, 0, 0, 1, 0, 32'd50, 16'd0);
        chk("pri_pre", saida_a, 32'd50);
        step(0, 0, 1, 0, 1, 1, 32'd99, 16'd0);
        chk("pri_saida", saida_a, 32'd7);
        chk("pri_nivel", {28'd0, nivel_a}, 32'd0);
        step(1, 1, 1, 1, 1, 1, 32'd99, 16'h0003);
        chk("stall_saida", saida_a, 32'd7);
        chk("stall_nivel", {28'd0, nivel_a}, 32'd0);
        chk("stall_erro", {30'd0, erro_a}, 32'd0);

        // Branch with negative offsets, then halt
        step(0, 0, 1, 0, 0, 0, 32'd20, 16'd0);
        step(0, 0, 0, 1, 0, 0, 32'd0, 16'hFFFB);
        chk("br_m5", saida_a, 32'd15);
        step(0, 0, 1, 0, 0, 0, 32'd0, 16'd0);
        step(0, 0, 0, 1, 0, 0, 32'd0, 16'hFFFF);
        chk("br_m1_a", saida_a, 32'hFFFF_FFFF);
        chk("br_m1_b", {24'd0, saida_b}, 32'hFF);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0, 0, 0, 0, 32'd0, 16'd0);
            chk("halt_hold", saida_a, 32'hFFFF_FFFF);
        end

        // Asynchronous reset landing mid-call
        do_reset();
        step(0, 0, 1, 0, 0, 0, 32'd10, 16'd0);
        call = 1'b1; endereco = 32'd100;
        #2 reseta = 1'b0;
        #1;
        chk("arst_saida", saida_a, 32'd0);
        chk("arst_nivel", {28'd0, nivel_a}, 32'd0);
        model_reset();
        @(posedge clock);
        @(negedge clock);
        check_all();
        reseta = 1'b1;
        idle();
        chk("arst_first", saida_a, 32'd1);
        step(0, 0, 0, 0, 0, 1, 32'd0, 16'd0);
        chk("arst_nopush", {30'd0, erro_a}, 32'd2);

        // Random traffic against the model
        do_reset();
        for (int n = 0; n < 600; n++) begin
            if (n % 150 == 149) do_reset();
            step($urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 6) == 0,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
                 $urandom, 16'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
